// File: rtl/dither_channel_sched.sv
// dither_channel_sched: RGB scheduler for a shared single-channel dither unit; optional pix_count via DITHER_SCHED_PERF_EN
module dither_channel_sched #(
  parameter int CH_W        = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sw,
  input  logic [3*CH_W-1:0] in_pixel,
  input  logic              in_sof,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [CH_W-1:0]   dith_channel,
  output logic              dith_sw,
  input  logic [CH_W-1:0]   dith_result,
  output logic [3*CH_W-1:0] out_pixel,
  output logic              out_sof,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              active_mode
`ifdef DITHER_SCHED_PERF_EN
  ,output logic [31:0]      pix_count
`endif
);
  typedef enum logic [2:0] {IDLE, CH_R, CH_G, CH_B, OUT} state_t;
  state_t                  state, state_n;
  logic [SYNC_STAGES-1:0]  sync;
  logic [3*CH_W-1:0]       pix;
  logic                    sof;
  always_comb begin
    state_n      = state;
    state_n      = (state == IDLE) ? (in_valid ? CH_R : IDLE) :
                   (state == CH_R) ? CH_G :
                   (state == CH_G) ? CH_B :
                   (state == CH_B) ? OUT  :
                   (out_ready ? IDLE : OUT);
    dith_channel = (state == CH_R) ? pix[3*CH_W-1:2*CH_W] :
                   (state == CH_G) ? pix[2*CH_W-1:CH_W] :
                   (state == CH_B) ? pix[CH_W-1:0] : '0;
    dith_sw      = active_mode;
    in_ready     = (state == IDLE);
    out_valid    = (state == OUT);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sync        <= '0;
      pix         <= '0;
      sof         <= 1'b0;
      active_mode <= 1'b0;
      out_pixel   <= '0;
      out_sof     <= 1'b0;
    end else begin
      state <= state_n;
      sync  <= {sync[SYNC_STAGES-2:0], sw};
      if (state == IDLE && in_valid) begin
        pix <= in_pixel;
        sof <= in_sof;
        // mode is only ever switched on a frame's first pixel
        if (in_sof) active_mode <= sync[SYNC_STAGES-1];
      end
      if (state == CH_R) out_pixel[3*CH_W-1:2*CH_W] <= dith_result;
      if (state == CH_G) out_pixel[2*CH_W-1:CH_W]   <= dith_result;
      if (state == CH_B) begin
        out_pixel[CH_W-1:0] <= dith_result;
        out_sof             <= sof;
      end
    end
  end
`ifdef DITHER_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pix_count <= '0;
    else if (out_valid && out_ready) pix_count <= out_sof ? 32'd1 : pix_count + 32'd1;
  end
`endif
endmodule
